// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
// Optional lock feature in the top is selected with macro ARB_LOCK_EN.
package arb_pkg;

   localparam int NREQ = 8;
   localparam int IDXW = 3;
   localparam int CNTW = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority encoder: finds the first set request at or after ptr,
// wrapping 7 -> 0, and returns its absolute index.
module rr_pick8
   import arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic            found,
   output logic [IDXW-1:0] pick_idx
);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic [IDXW-1:0]   first;

   always_comb begin
      // Doubling the vector turns the rotate-right into a plain shift.
      dbl   = {req, req} >> ptr;
      rot   = dbl[NREQ-1:0];
      first = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) first = IDXW'(i);
      end
      found    = |req;
      pick_idx = first + ptr;
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with per-grant beat limit and
// one-hot data select. Define ARB_LOCK_EN to add the lock input.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int MAX_BEATS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef ARB_LOCK_EN
   input  logic                  lock,
`endif
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] in_data,
   input  logic                  out_ready,
   output logic [NREQ-1:0]       gnt,
   output logic [IDXW-1:0]       gnt_idx,
   output logic [NREQ-1:0]       ack,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic                  busy
);

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

   logic            found;
   logic [IDXW-1:0] pick_idx;
   logic            lock_act;
   logic            xfer;
   logic            limit_hit;
   logic            release_gnt;

   rr_pick8 u_pick (
      .req      (req),
      .ptr      (ptr_q),
      .found    (found),
      .pick_idx (pick_idx)
   );

`ifdef ARB_LOCK_EN
   assign lock_act = lock;
`else
   assign lock_act = 1'b0;
`endif

   assign busy      = (state_q == BUSY);
   assign out_valid = busy && req[idx_q];
   assign xfer      = out_valid && out_ready;
   // >= rather than == so a grant held past the limit under lock frees on its next beat.
   assign limit_hit   = xfer && !lock_act && (int'(cnt_q) >= MAX_BEATS - 1);
   assign release_gnt = !req[idx_q] || limit_hit;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE) begin
         if (found) begin
            state_d = BUSY;
            gnt_d   = NREQ'(1) << pick_idx;
            idx_d   = pick_idx;
            cnt_d   = '0;
         end
      end else begin
         if (xfer && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
         if (release_gnt) begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            ptr_d   = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = idx_q;
   assign ack     = gnt_q & {NREQ{out_ready}};

   always_comb begin
      out_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         out_data = out_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt_q[i]}});
      end
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: one instance with MAX_BEATS=4, one with MAX_BEATS=1.
module tb_rr_arbiter8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   req = 8'h00;
   logic [127:0] in_data;
   logic         out_ready = 1'b0;
`ifdef ARB_LOCK_EN
   logic         lock = 1'b0;
`endif

   logic [7:0]  gnt4, ack4, gnt1, ack1;
   logic [2:0]  idx4, idx1;
   logic        ov4, busy4, ov1, busy1;
   logic [15:0] od4, od1;

   logic [15:0] din [8];
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rr_arbiter8 #(.WIDTH(16), .MAX_BEATS(4)) dut4 (
      .clk(clk), .rst(rst),
`ifdef ARB_LOCK_EN
      .lock(lock),
`endif
      .req(req), .in_data(in_data), .out_ready(out_ready),
      .gnt(gnt4), .gnt_idx(idx4), .ack(ack4), .out_valid(ov4),
      .out_data(od4), .busy(busy4)
   );

   rr_arbiter8 #(.WIDTH(16), .MAX_BEATS(1)) dut1 (
      .clk(clk), .rst(rst),
`ifdef ARB_LOCK_EN
      .lock(lock),
`endif
      .req(req), .in_data(in_data), .out_ready(out_ready),
      .gnt(gnt1), .gnt_idx(idx1), .ack(ack1), .out_valid(ov1),
      .out_data(od1), .busy(busy1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      out_ready = 1'b1;
      #3;
      n_checks++;
      if (gnt4 !== 8'h00 || idx4 !== 3'd0 || busy4 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state gnt=%h idx=%0d busy=%b, want 00/0/0", gnt4, idx4, busy4);
      end
      n_checks++;
      if (ov4 !== 1'b0 || od4 !== 16'h0000 || ack4 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs valid=%b data=%h ack=%h, want 0/0000/00", ov4, od4, ack4);
      end
      rst = 1'b0;
      step();
      n_checks++;
      if (gnt4 !== 8'h00 || busy4 !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_req gnt=%h busy=%b, want 00/0", gnt4, busy4);
      end
   endtask

   task automatic test_reset_mid_busy();
      req = 8'h04;
      out_ready = 1'b1;
      step();
      n_checks++;
      if (gnt4 !== 8'h04 || busy4 !== 1'b1 || ack4 !== 8'h04 || od4 !== din[2]) begin
         n_fail++;
         $display("FAIL mid_grant gnt=%h busy=%b ack=%h data=%h, want 04/1/04/%h",
                  gnt4, busy4, ack4, od4, din[2]);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (gnt4 !== 8'h00 || ack4 !== 8'h00 || busy4 !== 1'b0 || ov4 !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset gnt=%h ack=%h busy=%b valid=%b, want all 0",
                  gnt4, ack4, busy4, ov4);
      end
      rst = 1'b0;
      step();
      n_checks++;
      if (gnt4 !== 8'h04 || idx4 !== 3'd2) begin
         n_fail++;
         $display("FAIL regrant gnt=%h idx=%0d, want 04/2", gnt4, idx4);
      end
      req = 8'h00;
      step();
      n_checks++;
      if (gnt4 !== 8'h00 || busy4 !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_release gnt=%h busy=%b, want 00/0", gnt4, busy4);
      end
   endtask

   task automatic test_rotation();
      logic [7:0] exp_g;
      int         n;
      pulse_reset();
      req = 8'hFF;
      out_ready = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         step();
         n = ((k - 1) / 2) % 8;
         exp_g = (k % 2 == 1) ? 8'(1 << n) : 8'h00;
         n_checks++;
         if (gnt1 !== exp_g) begin
            n_fail++;
            $display("FAIL rotation_gnt cycle=%0d got %h want %h", k, gnt1, exp_g);
         end
         if (k % 2 == 1) begin
            n_checks++;
            if (od1 !== din[n] || idx1 !== 3'(n)) begin
               n_fail++;
               $display("FAIL rotation_data cycle=%0d data=%h idx=%0d, want %h/%0d",
                        k, od1, idx1, din[n], n);
            end
         end
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_beat_limit();
      logic [7:0] exp_g;
      pulse_reset();
      req = 8'h03;
      out_ready = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         exp_g = (k <= 4) ? 8'h01 : (k == 5) ? 8'h00 : 8'h02;
         n_checks++;
         if (gnt4 !== exp_g) begin
            n_fail++;
            $display("FAIL beat_limit cycle=%0d got %h want %h", k, gnt4, exp_g);
         end
      end
      n_checks++;
      if (od4 !== din[1] || ack4 !== 8'h02) begin
         n_fail++;
         $display("FAIL beat_limit_next data=%h ack=%h, want %h/02", od4, ack4, din[1]);
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_backpressure();
      logic       rdy [6];
      logic [7:0] exp_g;
      rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      pulse_reset();
      req = 8'h10;
      out_ready = 1'b0;
      step();
      n_checks++;
      if (gnt4 !== 8'h10 || ack4 !== 8'h00) begin
         n_fail++;
         $display("FAIL bp_grant gnt=%h ack=%h, want 10/00", gnt4, ack4);
      end
      for (int j = 0; j < 6; j++) begin
         out_ready = rdy[j];
         #1;
         n_checks++;
         if (ack4 !== (rdy[j] ? 8'h10 : 8'h00)) begin
            n_fail++;
            $display("FAIL bp_ack beat=%0d got %h want %h", j, ack4, rdy[j] ? 8'h10 : 8'h00);
         end
         step();
         exp_g = (j < 5) ? 8'h10 : 8'h00;
         n_checks++;
         if (gnt4 !== exp_g) begin
            n_fail++;
            $display("FAIL bp_gnt beat=%0d got %h want %h", j, gnt4, exp_g);
         end
      end
      req = 8'h31;
      step();
      n_checks++;
      if (gnt4 !== 8'h20) begin
         n_fail++;
         $display("FAIL bp_ptr gnt=%h want 20", gnt4);
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_early_drop_wrap();
      pulse_reset();
      req = 8'h40;
      out_ready = 1'b1;
      step();
      n_checks++;
      if (gnt4 !== 8'h40) begin
         n_fail++;
         $display("FAIL wrap_setup gnt=%h want 40", gnt4);
      end
      req = 8'h00;
      step();
      req = 8'h81;
      step();
      n_checks++;
      if (gnt4 !== 8'h80 || idx4 !== 3'd7) begin
         n_fail++;
         $display("FAIL wrap_pick gnt=%h idx=%0d, want 80/7", gnt4, idx4);
      end
      step();
      req = 8'h01;
      #1;
      n_checks++;
      if (gnt4 !== 8'h80 || ov4 !== 1'b0) begin
         n_fail++;
         $display("FAIL early_drop gnt=%h valid=%b, want 80/0", gnt4, ov4);
      end
      step();
      n_checks++;
      if (gnt4 !== 8'h00) begin
         n_fail++;
         $display("FAIL early_release gnt=%h want 00", gnt4);
      end
      step();
      n_checks++;
      if (gnt4 !== 8'h01 || idx4 !== 3'd0) begin
         n_fail++;
         $display("FAIL wrap_next gnt=%h idx=%0d, want 01/0", gnt4, idx4);
      end
      req = 8'h00;
      step();
   endtask

`ifdef ARB_LOCK_EN
   task automatic test_lock();
      pulse_reset();
      lock = 1'b1;
      req = 8'h01;
      out_ready = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         n_checks++;
         if (gnt4 !== 8'h01) begin
            n_fail++;
            $display("FAIL lock_hold cycle=%0d got %h want 01", k, gnt4);
         end
      end
      lock = 1'b0;
      step();
      n_checks++;
      if (gnt4 !== 8'h00) begin
         n_fail++;
         $display("FAIL lock_release gnt=%h want 00", gnt4);
      end
      req = 8'h00;
      step();
   endtask
`endif

   initial begin
      for (int i = 0; i < 8; i++) begin
         din[i] = 16'hA5C3 ^ 16'(i * 16'h1357);
         in_data[i*16 +: 16] = din[i];
      end
      test_reset();
      test_reset_mid_busy();
      test_rotation();
      test_beat_limit();
      test_backpressure();
      test_early_drop_wrap();
`ifdef ARB_LOCK_EN
      test_lock();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
